// File: rtl/m_dmem_resp.sv
// m_dmem_resp: word-addressed data-memory responder with a fixed access
// latency and a request/response handshake, one request in flight at a time.
// Owns a 2^ADDR_W x 32 RAM plus a memory-mapped LED register at MMIO_ADDR.
//
// Ports:
//   w_clk        clock, all state on posedge
//   w_rst        synchronous active-high reset
//   w_req_*      request channel (valid/ready, we, word addr, wdata)
//   w_rsp_*      response channel (valid/ready, rdata; rdata=0 for stores)
//   w_led        LED register contents
module m_dmem_resp #(
  parameter int unsigned ADDR_W    = 12,
  parameter int unsigned LATENCY   = 2,
  parameter int unsigned MMIO_ADDR = 'hfff
) (
  input  logic              w_clk,
  input  logic              w_rst,
  input  logic              w_req_valid,
  output logic              w_req_ready,
  input  logic              w_req_we,
  input  logic [ADDR_W-1:0] w_req_addr,
  input  logic [31:0]       w_req_wdata,
  output logic              w_rsp_valid,
  input  logic              w_rsp_ready,
  output logic [31:0]       w_rsp_rdata,
  output logic [31:0]       w_led
);

  localparam logic [ADDR_W-1:0] MMIO_A = ADDR_W'(MMIO_ADDR);
  localparam logic [3:0]        LAT_M1 = 4'(LATENCY - 1);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t              state, state_nx;
  logic [3:0]          cnt, cnt_nx;
  logic                we_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [31:0]         wdata_q;
  logic [31:0]         ram [0:(1<<ADDR_W)-1];

  logic                accept;
  logic                commit;
  logic                c_we;
  logic [ADDR_W-1:0]   c_addr;
  logic [31:0]         c_wdata;
  logic                c_mmio;

  assign w_req_ready = (state == IDLE) && !w_rst;
  assign accept      = w_req_valid && w_req_ready;
  assign c_mmio      = (c_addr == MMIO_A);

  // Commit happens on the edge that enters RESP. With LATENCY==1 that is the
  // accept edge itself, so the commit operands come straight from the request
  // inputs instead of the latched copy.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    commit   = 1'b0;
    c_we     = we_q;
    c_addr   = addr_q;
    c_wdata  = wdata_q;
    case (state)
      IDLE: begin
        if (accept) begin
          cnt_nx = LAT_M1;
          if (LATENCY == 1) begin
            state_nx = RESP;
            commit   = 1'b1;
            c_we     = w_req_we;
            c_addr   = w_req_addr;
            c_wdata  = w_req_wdata;
          end else begin
            state_nx = BUSY;
          end
        end
      end
      BUSY: begin
        cnt_nx = cnt - 4'd1;
        if (cnt == 4'd1) begin
          state_nx = RESP;
          commit   = 1'b1;
        end
      end
      RESP: begin
        if (w_rsp_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge w_clk) begin
    if (w_rst) begin
      state       <= IDLE;
      cnt         <= 4'd0;
      w_rsp_valid <= 1'b0;
      w_rsp_rdata <= 32'd0;
      w_led       <= 32'd0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      if (commit) begin
        w_rsp_valid <= 1'b1;
        if (c_we) begin
          w_rsp_rdata <= 32'd0;
          if (c_mmio) w_led <= c_wdata;
        end else begin
          w_rsp_rdata <= c_mmio ? w_led : ram[c_addr];
        end
      end else if (state == RESP && w_rsp_ready) begin
        w_rsp_valid <= 1'b0;
        w_rsp_rdata <= 32'd0;
      end
    end
  end

  // Request capture; only meaningful while BUSY, so no reset needed.
  always_ff @(posedge w_clk) begin
    if (accept) begin
      we_q    <= w_req_we;
      addr_q  <= w_req_addr;
      wdata_q <= w_req_wdata;
    end
  end

  // RAM is never cleared; reset suppresses a commit on the same edge so a
  // store aborted in BUSY leaves memory untouched.
  always_ff @(posedge w_clk) begin
    if (!w_rst && commit && c_we && !c_mmio) ram[c_addr] <= c_wdata;
  end

endmodule

// File: tb/tb_m_dmem_resp.sv
module tb_m_dmem_resp;

  logic        w_clk = 1'b0;
  logic        w_rst = 1'b1;

  // LATENCY=2 instance
  logic        req_valid = 1'b0, req_ready, req_we = 1'b0;
  logic [11:0] req_addr  = '0;
  logic [31:0] req_wdata = '0;
  logic        rsp_valid, rsp_ready = 1'b0;
  logic [31:0] rsp_rdata, led;

  // LATENCY=1 instance
  logic        req_valid1 = 1'b0, req_ready1, req_we1 = 1'b0;
  logic [11:0] req_addr1  = '0;
  logic [31:0] req_wdata1 = '0;
  logic        rsp_valid1, rsp_ready1 = 1'b1;
  logic [31:0] rsp_rdata1, led1;

  int checks = 0;
  int errors = 0;

  always #5 w_clk = ~w_clk;

  m_dmem_resp #(.ADDR_W(12), .LATENCY(2), .MMIO_ADDR('hfff)) u_dut (
    .w_clk(w_clk), .w_rst(w_rst),
    .w_req_valid(req_valid), .w_req_ready(req_ready), .w_req_we(req_we),
    .w_req_addr(req_addr), .w_req_wdata(req_wdata),
    .w_rsp_valid(rsp_valid), .w_rsp_ready(rsp_ready), .w_rsp_rdata(rsp_rdata),
    .w_led(led)
  );

  m_dmem_resp #(.ADDR_W(12), .LATENCY(1), .MMIO_ADDR('hfff)) u_dut1 (
    .w_clk(w_clk), .w_rst(w_rst),
    .w_req_valid(req_valid1), .w_req_ready(req_ready1), .w_req_we(req_we1),
    .w_req_addr(req_addr1), .w_req_wdata(req_wdata1),
    .w_rsp_valid(rsp_valid1), .w_rsp_ready(rsp_ready1), .w_rsp_rdata(rsp_rdata1),
    .w_led(led1)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One transaction on the LATENCY=2 instance. Response is held unacknowledged
  // for 'hold' extra cycles before the handshake.
  task automatic xact(input string tag, input logic we, input logic [11:0] addr,
                      input logic [31:0] wdata, input logic [31:0] exp_rdata,
                      input int hold);
    int lat;
    @(negedge w_clk);
    chk({tag, "_rdy_pre"}, 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata;
    @(posedge w_clk); #1;
    req_valid = 1'b0; req_we = 1'b0; req_wdata = 32'hx0x0_x0x0;
    @(negedge w_clk);
    lat = 0;
    while (!rsp_valid && lat < 20) begin
      chk({tag, "_rdy_busy"}, 32'(req_ready), 32'd0);
      @(posedge w_clk); lat++;
      @(negedge w_clk);
    end
    chk({tag, "_lat"}, lat, 32'd1);
    chk({tag, "_rdata"}, rsp_rdata, exp_rdata);
    chk({tag, "_rdy_resp"}, 32'(req_ready), 32'd0);
    repeat (hold) begin
      @(posedge w_clk); @(negedge w_clk);
      chk({tag, "_hold_vld"}, 32'(rsp_valid), 32'd1);
      chk({tag, "_hold_rdata"}, rsp_rdata, exp_rdata);
      chk({tag, "_hold_rdy"}, 32'(req_ready), 32'd0);
    end
    rsp_ready = 1'b1;
    @(posedge w_clk); #1;
    rsp_ready = 1'b0;
    @(negedge w_clk);
    chk({tag, "_post_vld"}, 32'(rsp_valid), 32'd0);
    chk({tag, "_post_rdata"}, rsp_rdata, 32'd0);
    chk({tag, "_post_rdy"}, 32'(req_ready), 32'd1);
  endtask

  initial begin
    // Reset
    repeat (2) @(posedge w_clk);
    @(negedge w_clk);
    chk("rdy_in_reset", 32'(req_ready), 32'd0);
    @(posedge w_clk); #1;
    w_rst = 1'b0;
    @(negedge w_clk);
    chk("rst_rdy", 32'(req_ready), 32'd1);
    chk("rst_vld", 32'(rsp_valid), 32'd0);
    chk("rst_led", led, 32'd0);
    chk("rst_rdata", rsp_rdata, 32'd0);

    // Store / load round trip
    xact("st8", 1'b1, 12'd8, 32'h55, 32'd0, 0);
    xact("ld8", 1'b0, 12'd8, 32'd0, 32'h55, 0);

    // Backpressured load
    xact("st0", 1'b1, 12'd0, 32'h222, 32'd0, 0);
    xact("ld0", 1'b0, 12'd0, 32'd0, 32'h222, 3);

    // MMIO LED
    xact("st_led", 1'b1, 12'hfff, 32'hdeadbeef, 32'd0, 0);
    chk("led_val", led, 32'hdeadbeef);
    xact("ld_led", 1'b0, 12'hfff, 32'd0, 32'hdeadbeef, 0);
    xact("ld8_again", 1'b0, 12'd8, 32'd0, 32'h55, 0);

    // Store aborted by reset in BUSY
    xact("st3", 1'b1, 12'd3, 32'h77, 32'd0, 0);
    @(negedge w_clk);
    req_valid = 1'b1; req_we = 1'b1; req_addr = 12'd3; req_wdata = 32'h1;
    @(posedge w_clk); #1;
    req_valid = 1'b0; req_we = 1'b0;
    @(negedge w_clk);
    chk("abort_busy_rdy", 32'(req_ready), 32'd0);
    w_rst = 1'b1;
    @(posedge w_clk); #1;
    w_rst = 1'b0;
    @(negedge w_clk);
    chk("abort_rdy", 32'(req_ready), 32'd1);
    chk("abort_led", led, 32'd0);
    repeat (3) begin
      chk("abort_vld", 32'(rsp_valid), 32'd0);
      @(posedge w_clk); @(negedge w_clk);
    end
    xact("ld3", 1'b0, 12'd3, 32'd0, 32'h77, 0);

    // LATENCY=1 instance, rsp_ready tied high
    @(negedge w_clk);
    chk("l1_rdy0", 32'(req_ready1), 32'd1);
    req_valid1 = 1'b1; req_we1 = 1'b1; req_addr1 = 12'd5; req_wdata1 = 32'h1234;
    @(posedge w_clk); #1;
    req_valid1 = 1'b0; req_we1 = 1'b0;
    @(negedge w_clk);
    chk("l1_st_vld", 32'(rsp_valid1), 32'd1);
    chk("l1_st_rdata", rsp_rdata1, 32'd0);
    chk("l1_st_rdy", 32'(req_ready1), 32'd0);
    @(posedge w_clk); @(negedge w_clk);
    chk("l1_st_done", 32'(rsp_valid1), 32'd0);
    chk("l1_rdy1", 32'(req_ready1), 32'd1);
    req_valid1 = 1'b1; req_we1 = 1'b0; req_addr1 = 12'd5;
    @(posedge w_clk); #1;
    req_valid1 = 1'b0;
    @(negedge w_clk);
    chk("l1_ld_vld", 32'(rsp_valid1), 32'd1);
    chk("l1_ld_rdata", rsp_rdata1, 32'h1234);
    @(posedge w_clk); @(negedge w_clk);
    chk("l1_ld_done", 32'(rsp_valid1), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
